lpc_periph_tpm: RTL and testbench

Parametrised LPC I/O and TPM-cycle peripheral. It supersedes the single-window I/O slave with NUM_WIN programmable address windows, optional TPM START (0101) decoding, and a request/response host handshake. While the host is busy it inserts long-wait SYNCs, with a bounded timeout that returns error SYNC. It sits between the board LAD/LFRAME# pins, via an external tristate pad, and the TPM register file.

---
 rtl/lpc_periph_tpm.sv | 269 ++++++++++++++++++++++++++
 tb/tb_lpc_periph_tpm.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_periph_tpm.sv
// LPC I/O and TPM-cycle peripheral with programmable address windows.
// Decodes host frames on LAD/LFRAME#, forwards one request per cycle to the
// register file, holds the bus in long-wait SYNC until the response arrives
// (or a timeout), then returns read data and hands the bus back.

module lpc_periph_tpm #(
   parameter int NUM_WIN    = 2,
   parameter int ENABLE_TPM = 1,
   parameter int MAX_WAIT   = 32,
   localparam int WIN_W     = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
   input  logic                  clk_i,
   input  logic                  nrst_i,
   input  logic                  lframe_i,
   input  logic [3:0]            lad_i,
   output logic [3:0]            lad_o,
   output logic                  lad_oe_o,
   input  logic [16*NUM_WIN-1:0] win_base_i,
   input  logic [16*NUM_WIN-1:0] win_mask_i,
   input  logic [NUM_WIN-1:0]    win_en_i,
   output logic                  req_valid_o,
   output logic                  req_write_o,
   output logic                  req_tpm_o,
   output logic [15:0]           req_addr_o,
   output logic [7:0]            req_wdata_o,
   output logic [WIN_W-1:0]      req_win_o,
   input  logic                  rsp_valid_i,
   input  logic [7:0]            rsp_rdata_i,
   output logic                  abort_o,
   output logic                  timeout_o,
   output logic [4:0]            state_o
);

   // CT is a reserved encoding: START decodes the cycle-type nibble directly
   // on the edge where LFRAME# rises, so the FSM never parks in CT.
   typedef enum logic [4:0] {
      IDLE   = 5'd0,
      START  = 5'd1,
      CT     = 5'd2,
      ADDR1  = 5'd3,
      ADDR2  = 5'd4,
      ADDR3  = 5'd5,
      ADDR4  = 5'd6,
      WDATA1 = 5'd7,
      WDATA2 = 5'd8,
      TAR1   = 5'd9,
      TAR2   = 5'd10,
      SYNC   = 5'd11,
      RDATA1 = 5'd12,
      RDATA2 = 5'd13,
      FTAR1  = 5'd14,
      FTAR2  = 5'd15,
      IGNORE = 5'd16
   } state_t;

   localparam logic [3:0] SYNC_READY = 4'h0;
   localparam logic [3:0] SYNC_LWAIT = 4'h6;
   localparam logic [3:0] SYNC_ERROR = 4'hA;

   state_t           state;
   logic [15:0]      addr_q;
   logic [3:0]       wdata_lo;
   logic [WIN_W-1:0] win_q;
   logic             is_write;
   logic             is_tpm;
   logic             pending;
   logic             rsp_done;
   logic [7:0]       rdata_q;
   logic [7:0]       wait_cnt;

   logic [15:0]      addr_full;
   logic             win_hit;
   logic [WIN_W-1:0] win_sel;
   logic             start_ok;
   logic             start_tpm;
   logic             rsp_now;

   // Address window decode on the final address nibble; the loop runs from the
   // top index down so the lowest matching window is the one that sticks.
   always_comb begin
      addr_full = {addr_q[15:4], lad_i};
      win_hit   = 1'b0;
      win_sel   = '0;
      for (int n = NUM_WIN - 1; n >= 0; n--) begin
         if (win_en_i[n] &&
             (((addr_full ^ win_base_i[16*n +: 16]) & win_mask_i[16*n +: 16]) == 16'h0000)) begin
            win_hit = 1'b1;
            win_sel = WIN_W'(n);
         end
      end
   end

   // START nibble qualification and "response available by this edge".
   always_comb begin
      start_tpm = (lad_i == 4'b0101);
      start_ok  = (lad_i == 4'b0000) || ((ENABLE_TPM != 0) && start_tpm);
      rsp_now   = rsp_done || (pending && rsp_valid_i);
   end

   // Frame sequencer: decodes the host cycle, issues the request, runs SYNC
   // and read-data phases, and restarts immediately whenever LFRAME# drops.
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state       <= IDLE;
         lad_o       <= 4'hF;
         req_valid_o <= 1'b0;
         req_write_o <= 1'b0;
         req_tpm_o   <= 1'b0;
         req_addr_o  <= 16'h0000;
         req_wdata_o <= 8'h00;
         req_win_o   <= '0;
         abort_o     <= 1'b0;
         timeout_o   <= 1'b0;
         addr_q      <= 16'h0000;
         wdata_lo    <= 4'h0;
         win_q       <= '0;
         is_write    <= 1'b0;
         is_tpm      <= 1'b0;
         pending     <= 1'b0;
         rsp_done    <= 1'b0;
         rdata_q     <= 8'h00;
         wait_cnt    <= 8'h00;
      end else begin
         req_valid_o <= 1'b0;
         abort_o     <= 1'b0;
         timeout_o   <= 1'b0;
         lad_o       <= 4'hF;

         if (pending && rsp_valid_i) begin
            pending  <= 1'b0;
            rsp_done <= 1'b1;
            rdata_q  <= rsp_rdata_i;
         end

         if (!lframe_i && (state != IDLE) && (state != START)) begin
            if (pending) begin
               abort_o  <= 1'b1;
               pending  <= 1'b0;
               rsp_done <= 1'b0;
            end
            wait_cnt <= 8'h00;
            is_tpm   <= start_tpm;
            state    <= start_ok ? START : IGNORE;
         end else begin
            case (state)
               IDLE: begin
                  if (!lframe_i) begin
                     is_tpm <= start_tpm;
                     state  <= start_ok ? START : IGNORE;
                  end
               end
               START, CT: begin
                  if (!lframe_i) begin
                     is_tpm <= start_tpm;
                     state  <= start_ok ? START : IGNORE;
                  end else begin
                     case (lad_i)
                        4'b0000: begin
                           is_write <= 1'b0;
                           state    <= ADDR1;
                        end
                        4'b0010: begin
                           is_write <= 1'b1;
                           state    <= ADDR1;
                        end
                        default: state <= IGNORE;
                     endcase
                  end
               end
               ADDR1: begin
                  addr_q[15:12] <= lad_i;
                  state         <= ADDR2;
               end
               ADDR2: begin
                  addr_q[11:8] <= lad_i;
                  state        <= ADDR3;
               end
               ADDR3: begin
                  addr_q[7:4] <= lad_i;
                  state       <= ADDR4;
               end
               ADDR4: begin
                  addr_q[3:0] <= lad_i;
                  win_q       <= win_sel;
                  if (!win_hit) begin
                     state <= IGNORE;
                  end else if (is_write) begin
                     state <= WDATA1;
                  end else begin
                     req_valid_o <= 1'b1;
                     req_write_o <= 1'b0;
                     req_tpm_o   <= is_tpm;
                     req_addr_o  <= addr_full;
                     req_win_o   <= win_sel;
                     pending     <= 1'b1;
                     rsp_done    <= 1'b0;
                     state       <= TAR1;
                  end
               end
               WDATA1: begin
                  wdata_lo <= lad_i;
                  state    <= WDATA2;
               end
               WDATA2: begin
                  req_valid_o <= 1'b1;
                  req_write_o <= 1'b1;
                  req_tpm_o   <= is_tpm;
                  req_addr_o  <= addr_q;
                  req_wdata_o <= {lad_i, wdata_lo};
                  req_win_o   <= win_q;
                  pending     <= 1'b1;
                  rsp_done    <= 1'b0;
                  state       <= TAR1;
               end
               TAR1: state <= TAR2;
               TAR2: begin
                  state <= SYNC;
                  if (rsp_now) begin
                     lad_o    <= SYNC_READY;
                     wait_cnt <= 8'h00;
                  end else begin
                     lad_o    <= SYNC_LWAIT;
                     wait_cnt <= 8'h01;
                  end
               end
               SYNC: begin
                  if (lad_o == SYNC_LWAIT) begin
                     if (rsp_now) begin
                        lad_o <= SYNC_READY;
                     end else if (wait_cnt == 8'(MAX_WAIT)) begin
                        lad_o     <= SYNC_ERROR;
                        timeout_o <= 1'b1;
                        pending   <= 1'b0;
                        rdata_q   <= 8'hFF;
                     end else begin
                        lad_o    <= SYNC_LWAIT;
                        wait_cnt <= wait_cnt + 8'd1;
                     end
                  end else begin
                     wait_cnt <= 8'h00;
                     if (is_write) begin
                        state <= FTAR1;
                     end else begin
                        lad_o <= rdata_q[3:0];
                        state <= RDATA1;
                     end
                  end
               end
               RDATA1: begin
                  lad_o <= rdata_q[7:4];
                  state <= RDATA2;
               end
               RDATA2: state <= FTAR1;
               FTAR1:  state <= FTAR2;
               FTAR2:  state <= IDLE;
               IGNORE: state <= IGNORE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   // The pad is only driven in our own phases, and LFRAME# low releases it
   // in the same cycle without waiting for the next edge.
   assign lad_oe_o = lframe_i && ((state == SYNC) || (state == RDATA1) ||
                                  (state == RDATA2) || (state == FTAR1));
   assign state_o  = state;

endmodule

// File: tb/tb_lpc_periph_tpm.sv
// Directed bench for lpc_periph_tpm: I/O write, TPM read with long waits,
// window miss, timeout, abort, ignored cycle types and mid-frame reset.

module tb_lpc_periph_tpm;

   localparam logic [4:0] ST_IDLE   = 5'd0;
   localparam logic [4:0] ST_START  = 5'd1;
   localparam logic [4:0] ST_WDATA1 = 5'd7;
   localparam logic [4:0] ST_WDATA2 = 5'd8;
   localparam logic [4:0] ST_SYNC   = 5'd11;
   localparam logic [4:0] ST_IGNORE = 5'd16;

   logic        clock;
   logic        nrst;
   logic        lframe;
   logic [3:0]  lad_in;
   logic [31:0] win_base;
   logic [31:0] win_mask;
   logic [1:0]  win_en;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;

   logic [3:0]  lad_out;
   logic        lad_oe;
   logic        req_valid;
   logic        req_write;
   logic        req_tpm;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic [0:0]  req_win;
   logic        abort_p;
   logic        timeout_p;
   logic [4:0]  state;

   logic [3:0]  lad_out2;
   logic        lad_oe2;
   logic        req_valid2;
   logic        req_write2;
   logic        req_tpm2;
   logic [15:0] req_addr2;
   logic [7:0]  req_wdata2;
   logic [0:0]  req_win2;
   logic        abort_p2;
   logic        timeout_p2;
   logic [4:0]  state2;

   int check_count;
   int error_count;
   logic saw_oe;
   logic saw_req;

   lpc_periph_tpm #(.NUM_WIN(2), .ENABLE_TPM(1), .MAX_WAIT(4)) dut (
      .clk_i(clock), .nrst_i(nrst), .lframe_i(lframe), .lad_i(lad_in),
      .lad_o(lad_out), .lad_oe_o(lad_oe),
      .win_base_i(win_base), .win_mask_i(win_mask), .win_en_i(win_en),
      .req_valid_o(req_valid), .req_write_o(req_write), .req_tpm_o(req_tpm),
      .req_addr_o(req_addr), .req_wdata_o(req_wdata), .req_win_o(req_win),
      .rsp_valid_i(rsp_valid), .rsp_rdata_i(rsp_rdata),
      .abort_o(abort_p), .timeout_o(timeout_p), .state_o(state)
   );

   lpc_periph_tpm #(.NUM_WIN(2), .ENABLE_TPM(0), .MAX_WAIT(4)) dut_notpm (
      .clk_i(clock), .nrst_i(nrst), .lframe_i(lframe), .lad_i(lad_in),
      .lad_o(lad_out2), .lad_oe_o(lad_oe2),
      .win_base_i(win_base), .win_mask_i(win_mask), .win_en_i(win_en),
      .req_valid_o(req_valid2), .req_write_o(req_write2), .req_tpm_o(req_tpm2),
      .req_addr_o(req_addr2), .req_wdata_o(req_wdata2), .req_win_o(req_win2),
      .rsp_valid_i(rsp_valid), .rsp_rdata_i(rsp_rdata),
      .abort_o(abort_p2), .timeout_o(timeout_p2), .state_o(state2)
   );

   // 10 ns LPC clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one bus cycle on the falling edge, then let outputs settle
   task automatic applyStimulus(input logic fr, input logic [3:0] nib, input logic rv, input logic [7:0] rd);
      @(negedge clock);
      lframe    = fr;
      lad_in    = nib;
      rsp_valid = rv;
      rsp_rdata = rd;
      #1;
      if (lad_oe)    saw_oe  = 1'b1;
      if (req_valid) saw_req = 1'b1;
   endtask

   // Four address nibbles, most significant first
   task automatic sendAddr(input logic [15:0] a);
      applyStimulus(1'b1, a[15:12], 1'b0, 8'h00);
      applyStimulus(1'b1, a[11:8],  1'b0, 8'h00);
      applyStimulus(1'b1, a[7:4],   1'b0, 8'h00);
      applyStimulus(1'b1, a[3:0],   1'b0, 8'h00);
   endtask

   // START, CT and address: cycles 0 to 5 of a frame
   task automatic sendHeader(input logic [3:0] st, input logic [3:0] ct, input logic [15:0] a);
      applyStimulus(1'b0, st, 1'b0, 8'h00);
      applyStimulus(1'b1, ct, 1'b0, 8'h00);
      sendAddr(a);
   endtask

   initial begin
      check_count = 0;
      error_count = 0;
      saw_oe      = 1'b0;
      saw_req     = 1'b0;
      nrst        = 1'b0;
      lframe      = 1'b1;
      lad_in      = 4'hF;
      rsp_valid   = 1'b0;
      rsp_rdata   = 8'h00;
      win_base    = {16'hD400, 16'h0080};
      win_mask    = {16'hF000, 16'hFFFF};
      win_en      = 2'b11;

      #12;
      checkOutput("rst_state", 32'(state), 32'(ST_IDLE));
      checkOutput("rst_oe", 32'(lad_oe), 32'd0);
      checkOutput("rst_lad", 32'(lad_out), 32'hF);
      checkOutput("rst_req", 32'(req_valid), 32'd0);
      checkOutput("rst_addr", 32'(req_addr), 32'd0);
      @(negedge clock);
      nrst = 1'b1;

      $display("[TB] I/O write 0x0080 <= 0x5A");
      sendHeader(4'h0, 4'h2, 16'h0080);
      applyStimulus(1'b1, 4'hA, 1'b0, 8'h00);
      checkOutput("wr_notpm_state", 32'(state2), 32'(ST_WDATA1));
      applyStimulus(1'b1, 4'h5, 1'b0, 8'h00);
      checkOutput("wr_noreq_c7", 32'(req_valid), 32'd0);
      applyStimulus(1'b1, 4'hF, 1'b1, 8'h00);
      checkOutput("wr_req", 32'(req_valid), 32'd1);
      checkOutput("wr_write", 32'(req_write), 32'd1);
      checkOutput("wr_tpm", 32'(req_tpm), 32'd0);
      checkOutput("wr_addr", 32'(req_addr), 32'h0080);
      checkOutput("wr_wdata", 32'(req_wdata), 32'h5A);
      checkOutput("wr_win", 32'(req_win), 32'd0);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("wr_req_pulse", 32'(req_valid), 32'd0);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("wr_sync_oe", 32'(lad_oe), 32'd1);
      checkOutput("wr_sync", 32'(lad_out), 32'h0);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("wr_ftar_oe", 32'(lad_oe), 32'd1);
      checkOutput("wr_ftar", 32'(lad_out), 32'hF);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("wr_float", 32'(lad_oe), 32'd0);

      $display("[TB] TPM read 0xD40C, response 0xA7 after two long waits");
      sendHeader(4'h5, 4'h0, 16'hD40C);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("tpm_notpm_ignore", 32'(state2), 32'(ST_IGNORE));
      checkOutput("tpm_req", 32'(req_valid), 32'd1);
      checkOutput("tpm_flag", 32'(req_tpm), 32'd1);
      checkOutput("tpm_write", 32'(req_write), 32'd0);
      checkOutput("tpm_addr", 32'(req_addr), 32'hD40C);
      checkOutput("tpm_win", 32'(req_win), 32'd1);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("tpm_sync1", 32'(lad_out), 32'h6);
      applyStimulus(1'b1, 4'hF, 1'b1, 8'hA7);
      checkOutput("tpm_sync2", 32'(lad_out), 32'h6);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("tpm_sync3", 32'(lad_out), 32'h0);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("tpm_rd_lo", 32'(lad_out), 32'h7);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("tpm_rd_hi", 32'(lad_out), 32'hA);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("tpm_ftar", 32'(lad_out), 32'hF);
      checkOutput("tpm_ftar_oe", 32'(lad_oe), 32'd1);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("tpm_float", 32'(lad_oe), 32'd0);

      $display("[TB] I/O read 0x0060 with no window hit");
      saw_oe  = 1'b0;
      saw_req = 1'b0;
      sendHeader(4'h0, 4'h0, 16'h0060);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("miss_oe", 32'(saw_oe), 32'd0);
      checkOutput("miss_req", 32'(saw_req), 32'd0);
      checkOutput("miss_state", 32'(state), 32'(ST_IGNORE));

      $display("[TB] I/O read 0x0080 with no response");
      sendHeader(4'h0, 4'h0, 16'h0080);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("to_req", 32'(req_valid), 32'd1);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
         checkOutput($sformatf("to_lwait%0d", i), 32'(lad_out), 32'h6);
         checkOutput($sformatf("to_nopulse%0d", i), 32'(timeout_p), 32'd0);
      end
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("to_err", 32'(lad_out), 32'hA);
      checkOutput("to_pulse", 32'(timeout_p), 32'd1);
      applyStimulus(1'b1, 4'hF, 1'b1, 8'h00);
      checkOutput("to_rd_lo", 32'(lad_out), 32'hF);
      checkOutput("to_pulse_end", 32'(timeout_p), 32'd0);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("to_rd_hi", 32'(lad_out), 32'hF);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("to_ftar", 32'(lad_out), 32'hF);
      checkOutput("to_ftar_oe", 32'(lad_oe), 32'd1);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("to_float", 32'(lad_oe), 32'd0);

      $display("[TB] Abort during long wait, then a normal write");
      sendHeader(4'h0, 4'h2, 16'h0080);
      applyStimulus(1'b1, 4'h1, 1'b0, 8'h00);
      applyStimulus(1'b1, 4'h1, 1'b0, 8'h00);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("ab_wait_oe", 32'(lad_oe), 32'd1);
      checkOutput("ab_wait", 32'(lad_out), 32'h6);
      applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);
      checkOutput("ab_release", 32'(lad_oe), 32'd0);
      checkOutput("ab_still_sync", 32'(state), 32'(ST_SYNC));
      applyStimulus(1'b1, 4'h2, 1'b1, 8'h99);
      checkOutput("ab_pulse", 32'(abort_p), 32'd1);
      checkOutput("ab_restart", 32'(state), 32'(ST_START));
      sendAddr(16'h0080);
      checkOutput("ab_pulse_end", 32'(abort_p), 32'd0);
      applyStimulus(1'b1, 4'h3, 1'b0, 8'h00);
      applyStimulus(1'b1, 4'hC, 1'b0, 8'h00);
      applyStimulus(1'b1, 4'hF, 1'b1, 8'h00);
      checkOutput("ab2_req", 32'(req_valid), 32'd1);
      checkOutput("ab2_wdata", 32'(req_wdata), 32'hC3);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("ab2_sync", 32'(lad_out), 32'h0);
      checkOutput("ab2_sync_oe", 32'(lad_oe), 32'd1);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("ab2_float", 32'(lad_oe), 32'd0);

      $display("[TB] Memory cycle is ignored");
      saw_oe  = 1'b0;
      saw_req = 1'b0;
      applyStimulus(1'b0, 4'h0, 1'b0, 8'h00);
      applyStimulus(1'b1, 4'h4, 1'b0, 8'h00);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("mem_state", 32'(state), 32'(ST_IGNORE));
      checkOutput("mem_oe", 32'(saw_oe), 32'd0);
      checkOutput("mem_req", 32'(saw_req), 32'd0);

      $display("[TB] Asynchronous reset during WDATA2");
      sendHeader(4'h0, 4'h2, 16'h0080);
      applyStimulus(1'b1, 4'h7, 1'b0, 8'h00);
      applyStimulus(1'b1, 4'h7, 1'b0, 8'h00);
      checkOutput("rs_pre_state", 32'(state), 32'(ST_WDATA2));
      checkOutput("rs_pre_addr", 32'(req_addr), 32'h0080);
      nrst = 1'b0;
      #1;
      checkOutput("rs_state", 32'(state), 32'(ST_IDLE));
      checkOutput("rs_oe", 32'(lad_oe), 32'd0);
      checkOutput("rs_lad", 32'(lad_out), 32'hF);
      checkOutput("rs_req", 32'(req_valid), 32'd0);
      checkOutput("rs_write", 32'(req_write), 32'd0);
      checkOutput("rs_tpm", 32'(req_tpm), 32'd0);
      checkOutput("rs_addr", 32'(req_addr), 32'd0);
      checkOutput("rs_wdata", 32'(req_wdata), 32'd0);
      checkOutput("rs_win", 32'(req_win), 32'd0);
      checkOutput("rs_abort", 32'(abort_p), 32'd0);
      checkOutput("rs_timeout", 32'(timeout_p), 32'd0);
      @(negedge clock);
      nrst = 1'b1;
      applyStimulus(1'b1, 4'hF, 1'b0, 8'h00);
      checkOutput("rs_after", 32'(state), 32'(ST_IDLE));

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
